// File: rtl/row_clear_ctrl.sv
// ============================================================================
// Module   : row_clear_ctrl
// Purpose  : Compacts the Tetris board after a piece locks and counts cleared rows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            clear_total_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      lines_cleared_o,
  output logic [15:0]     total_lines_o,
  output logic [4:0]      rd_addr_o,
  input  logic [COLS-1:0] rd_data_i,
  output logic            wr_en_o,
  output logic [4:0]      wr_addr_o,
  output logic [COLS-1:0] wr_data_o
);

  localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EVAL = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [4:0]  src_q;
  logic [4:0]  dst_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  lines_q;
  logic [15:0] total_q;

  logic        row_full;
  logic [4:0]  cnt_d;
  logic [15:0] total_base;
  logic [16:0] total_sum;
  logic [15:0] total_d;

  assign row_full = &rd_data_i;
  assign cnt_d    = cnt_q + {4'd0, row_full};

  // A clear coincident with DONE zeroes the base before this operation's count is added.
  assign total_base = clear_total_i ? 16'd0 : total_q;
  assign total_sum  = {1'b0, total_base} + {12'd0, cnt_q};

  always_comb begin
    total_d = total_q;
    if (state_q == S_DONE) begin
      total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end else if (clear_total_i) begin
      total_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 5'd0;
      dst_q   <= 5'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lines_q <= 5'd0;
      total_q <= 16'd0;
    end else begin
      done_q  <= 1'b0;
      total_q <= total_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q   <= C_LAST_ROW;
            dst_q   <= C_LAST_ROW;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: state_q <= S_EVAL;
        S_EVAL: begin
          cnt_q <= cnt_d;
          if (!row_full) dst_q <= dst_q - 5'd1;
          if (src_q == 5'd0) begin
            if (cnt_d != 5'd0) begin
              state_q <= S_FILL;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              lines_q <= cnt_d;
            end
          end else begin
            src_q   <= src_q - 5'd1;
            state_q <= S_READ;
          end
        end
        S_FILL: begin
          dst_q <= dst_q - 5'd1;
          if (dst_q == 5'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            lines_q <= cnt_q;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Writes always land on rows already read, so the board needs no bypass path.
  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = dst_q;
    wr_data_o = '0;
    if (state_q == S_EVAL) begin
      wr_en_o   = !row_full && (dst_q != src_q);
      wr_data_o = rd_data_i;
    end else if (state_q == S_FILL) begin
      wr_en_o   = 1'b1;
    end
  end

  assign rd_addr_o       = src_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign lines_cleared_o = lines_q;
  assign total_lines_o   = total_q;

endmodule

`default_nettype wire

// File: tb/tb_row_clear_ctrl.sv
// ============================================================================
// Module   : tb_row_clear_ctrl
// Purpose  : Directed and random checks of row_clear_ctrl against a board model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_row_clear_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear_total = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  lines_cleared;
  logic [15:0] total_lines;
  logic [4:0]  rd_addr;
  logic [11:0] rd_data = 12'd0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;

  logic [11:0] board [20];
  logic [11:0] img   [20];
  logic        load = 1'b0;

  int checks = 0;
  int errors = 0;
  int model_total = 0;

  row_clear_ctrl #(.ROWS(20), .COLS(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .clear_total_i   (clear_total),
    .busy_o          (busy),
    .done_o          (done),
    .lines_cleared_o (lines_cleared),
    .total_lines_o   (total_lines),
    .rd_addr_o       (rd_addr),
    .rd_data_i       (rd_data),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data)
  );

  always #5 clk = ~clk;

  // Board register file: registered read, write on strobe, bulk load from img.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 20; i++) board[i] <= img[i];
    end else if (wr_en && wr_addr < 5'd20) begin
      board[wr_addr] <= wr_data;
    end
    rd_data <= (rd_addr < 5'd20) ? board[rd_addr] : 12'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 20; i++) img[i] = 12'd0;
  endtask

  task automatic rand_img();
    for (int i = 0; i < 20; i++)
      img[i] = ($urandom_range(0, 2) == 0) ? 12'hFFF : 12'($urandom);
  endtask

  // One full compaction; entered and left on a falling edge, start asserted in cycle 0.
  task automatic run_op(input string tag, input bit clr_done, input bit interlock, input int exp_nwr);
    logic [11:0] kept [$];
    logic [11:0] expb [20];
    int k, lat, nwr;
    bit seen, busy_bad, row0_wr;
    kept.delete();
    for (int r = 19; r >= 0; r--)
      if (img[r] != 12'hFFF) kept.push_back(img[r]);
    k = 20 - kept.size();
    for (int r = 0; r < 20; r++)
      expb[r] = (19 - r < kept.size()) ? kept[19 - r] : 12'd0;

    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nwr = 0; seen = 0; busy_bad = 0; row0_wr = 0;
    while (lat < 100) begin
      if (done) begin seen = 1; break; end
      if (busy !== 1'b1) busy_bad = 1;
      if (wr_en === 1'b1) begin
        nwr++;
        if (wr_addr == 5'd0) row0_wr = 1;
      end
      start = interlock && (lat == 10);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(41 + k));
    chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(k));
    if (exp_nwr >= 0) chk({tag, "_writes"}, 32'(nwr), 32'(exp_nwr));
    if (k > 0) chk({tag, "_row0_filled"}, 32'(row0_wr), 32'd1);

    start = interlock;
    clear_total = clr_done;
    model_total = clr_done ? k : ((model_total + k > 65535) ? 65535 : model_total + k);
    @(negedge clk);
    start = 1'b0;
    clear_total = 1'b0;
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_total"}, 32'(total_lines), 32'(model_total));
    chk({tag, "_lines_held"}, 32'(lines_cleared), 32'(k));
    for (int r = 0; r < 20; r++)
      chk($sformatf("%s_row%0d", tag, r), 32'(board[r]), 32'(expb[r]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_total", 32'(total_lines), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    clear_img();
    run_op("empty", 1'b0, 1'b0, 0);

    clear_img();
    img[19] = 12'hFFF;
    img[18] = 12'h001;
    run_op("single", 1'b0, 1'b0, -1);

    clear_img();
    for (int r = 16; r < 20; r++) img[r] = 12'hFFF;
    img[15] = 12'h0F0;
    run_op("tetris", 1'b0, 1'b0, -1);

    force dut.total_q = 16'd65534;
    @(negedge clk);
    release dut.total_q;
    model_total = 65534;
    chk("preload_total", 32'(total_lines), 32'd65534);
    run_op("saturate", 1'b0, 1'b0, -1);

    clear_img();
    img[19] = 12'hFFF;
    img[17] = 12'hFFF;
    img[18] = 12'h5A5;
    run_op("clr_at_done", 1'b1, 1'b0, -1);

    clear_total = 1'b1;
    @(negedge clk);
    clear_total = 1'b0;
    model_total = 0;
    chk("clr_idle_total", 32'(total_lines), 32'd0);

    rand_img();
    run_op("interlock", 1'b0, 1'b1, -1);
    rand_img();
    run_op("restart", 1'b0, 1'b0, -1);

    rand_img();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_total", 32'(total_lines), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_lines", 32'(lines_cleared), 32'd0);
    rst = 1'b0;
    model_total = 0;
    @(negedge clk);
    rand_img();
    run_op("after_rst", 1'b0, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      rand_img();
      run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
